// File: rtl/senone_normalise_if.sv
// Normalised score stream from senone_normalise to the search/pruning stage.
interface senone_normalise_if;
    logic               norm_valid;
    logic               norm_ready;
    logic signed [15:0] norm_score;
    logic               norm_last;

    modport master (output norm_valid, norm_score, norm_last, input norm_ready);
    modport slave  (input norm_valid, norm_score, norm_last, output norm_ready);
endinterface

// File: rtl/senone_normalise.sv
// Buffers one frame of senone scores, then replays them as sat16(score - best)
// over a valid/ready stream once the max-finder reports the frame maximum.
module senone_normalise #(
    parameter int MAX_SENONES = 256,
    parameter int AW          = $clog2(MAX_SENONES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_senone,
    input  logic                last_senone,
    input  logic signed [15:0]  current_score,
    input  logic signed [15:0]  best_score,
    input  logic                max_done,
    senone_normalise_if.master  norm,
    output logic                busy,
    output logic                error
);
    typedef enum logic [1:0] {FILL, WAIT_MAX, DRAIN} state_t;

    typedef struct packed {
        logic signed [15:0] score;
        logic               last;
    } beat_t;

    localparam logic [AW:0] DEPTH = (AW+1)'(MAX_SENONES);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    state_t             state, state_nx;
    logic [AW:0]        wr_ptr, rd_ptr, count;
    logic signed [15:0] best_q, rd_data, sat;
    logic signed [15:0] mem [MAX_SENONES];
    logic               rd_inflight, rd_last;
    beat_t              skid [2];
    logic               skid_wr, skid_rd;
    logic [1:0]         skid_cnt;

    logic        wr_en, frame_end, pop, done, rd_go;
    logic [2:0]  occ;
    logic [16:0] diff;

    assign wr_en     = (state == FILL) && new_senone && (wr_ptr != DEPTH);
    assign frame_end = (state == FILL) && new_senone && last_senone;
    assign pop       = norm.norm_valid && norm.norm_ready;
    assign done      = pop && skid[skid_rd].last;

    // Reads are issued only when the 2-entry skid can absorb them, counting
    // the read already in flight and the beat leaving this cycle.
    assign occ   = {1'b0, skid_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
    assign rd_go = ((state == DRAIN) || (state == WAIT_MAX && max_done))
                   && (rd_ptr < count) && (occ < 3'd2);

    assign diff = {rd_data[15], rd_data} - {best_q[15], best_q};

    always_comb begin
        sat = diff[15:0];
        if (diff[16] != diff[15])
            sat = diff[16] ? 16'sh8000 : 16'sh7fff;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL:     if (frame_end) state_nx = WAIT_MAX;
            WAIT_MAX: if (count == '0) state_nx = FILL;
                      else if (max_done) state_nx = DRAIN;
            DRAIN:    if (done) state_nx = FILL;
            default:  state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            best_q      <= '0;
            error       <= 1'b0;
            rd_inflight <= 1'b0;
            rd_last     <= 1'b0;
            skid[0]     <= '0;
            skid[1]     <= '0;
            skid_wr     <= 1'b0;
            skid_rd     <= 1'b0;
            skid_cnt    <= '0;
        end else begin
            if (done)       wr_ptr <= '0;
            else if (wr_en) wr_ptr <= wr_ptr + ONE;
            if (done)       rd_ptr <= '0;
            else if (rd_go) rd_ptr <= rd_ptr + ONE;
            if (frame_end)  count <= wr_ptr + {{AW{1'b0}}, wr_en};
            if (state == WAIT_MAX && max_done) best_q <= best_score;
            if (new_senone && (state != FILL || wr_ptr == DEPTH)) error <= 1'b1;
            rd_inflight <= rd_go;
            if (rd_go) rd_last <= (rd_ptr + ONE == count);
            if (rd_inflight) begin
                skid[skid_wr] <= '{score: sat, last: rd_last};
                skid_wr       <= ~skid_wr;
            end
            if (pop) skid_rd <= ~skid_rd;
            skid_cnt <= skid_cnt + {1'b0, rd_inflight} - {1'b0, pop};
        end
    end

    // Frame buffer: no reset, contents are meaningless outside a frame.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= current_score;
        if (rd_go) rd_data <= mem[rd_ptr[AW-1:0]];
    end

    assign norm.norm_valid = (skid_cnt != 2'd0);
    assign norm.norm_score = skid[skid_rd].score;
    assign norm.norm_last  = skid[skid_rd].last;
    assign busy            = (state != FILL);
endmodule

// File: tb/tb_senone_normalise.sv
// Two instances (deep and 4-entry buffer) share stimulus; a queue model checks every cycle.
module tb_senone_normalise;
    logic clk = 1'b0, reset = 1'b1;
    logic new_senone = 1'b0, last_senone = 1'b0, max_done = 1'b0, ready = 1'b1;
    logic signed [15:0] current_score = '0, best_score = '0;

    logic v [2], l [2], bz [2], er [2];
    logic signed [15:0] s [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        senone_normalise_if nif ();
        assign nif.norm_ready = ready;
        senone_normalise #(.MAX_SENONES(g == 0 ? 256 : 4)) dut (
            .clk(clk), .reset(reset), .new_senone(new_senone), .last_senone(last_senone),
            .current_score(current_score), .best_score(best_score), .max_done(max_done),
            .norm(nif), .busy(bz[g]), .error(er[g]));
        assign v[g] = nif.norm_valid;
        assign s[g] = nif.norm_score;
        assign l[g] = nif.norm_last;
    end

    int depth [2] = '{256, 4};
    int fbuf [2][256];
    int fn [2];
    int exs [2][256];
    bit exl [2][256];
    int eh [2], et [2];
    int obs_s [2][256];
    bit obs_l [2][256];
    int on [2];
    bit mbusy [2], mwait [2], merr [2], fpend [2], pst [2], pl [2];
    int ps [2], mdc [2];
    int cyc, checks, failures;
    int fq [$], eq_s [$];
    bit eq_l [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat16(input int d);
        return (d > 32767) ? 32767 : (d < -32768) ? -32768 : d;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            bit was_busy, pop;
            if (reset) begin
                chk($sformatf("u%0d rst_valid", i), int'(v[i]), 0);
                chk($sformatf("u%0d rst_busy", i), int'(bz[i]), 0);
                chk($sformatf("u%0d rst_error", i), int'(er[i]), 0);
                mbusy[i] = 0; mwait[i] = 0; merr[i] = 0; fpend[i] = 0; pst[i] = 0;
                fn[i] = 0; eh[i] = 0; et[i] = 0;
                continue;
            end
            chk($sformatf("u%0d busy", i), int'(bz[i]), int'(mbusy[i]));
            chk($sformatf("u%0d error", i), int'(er[i]), int'(merr[i]));
            if (pst[i]) begin
                chk($sformatf("u%0d hold_valid", i), int'(v[i]), 1);
                chk($sformatf("u%0d hold_score", i), int'(s[i]), ps[i]);
                chk($sformatf("u%0d hold_last", i), int'(l[i]), int'(pl[i]));
            end
            if (v[i]) begin
                if (eh[i] == et[i]) chk($sformatf("u%0d extra_beat", i), int'(v[i]), 0);
                else begin
                    chk($sformatf("u%0d score", i), int'(s[i]), exs[i][eh[i]]);
                    chk($sformatf("u%0d last", i), int'(l[i]), int'(exl[i][eh[i]]));
                end
                if (fpend[i]) begin
                    chk($sformatf("u%0d latency", i), cyc - mdc[i], 2);
                    fpend[i] = 0;
                end
            end
            was_busy = mbusy[i];
            pop      = v[i] && ready;
            pst[i]   = v[i] && !ready;
            ps[i]    = int'(s[i]);
            pl[i]    = l[i];
            if (pop) begin
                if (on[i] < 256) begin
                    obs_s[i][on[i]] = int'(s[i]); obs_l[i][on[i]] = l[i]; on[i]++;
                end
                if (eh[i] != et[i]) begin
                    if (exl[i][eh[i]]) begin
                        mbusy[i] = 0; fn[i] = 0; eh[i] = 0; et[i] = 0;
                    end else eh[i]++;
                end
            end
            if (mwait[i] && max_done) begin
                for (int k = 0; k < fn[i]; k++) begin
                    exs[i][et[i]] = sat16(fbuf[i][k] - int'(best_score));
                    exl[i][et[i]] = (k == fn[i] - 1);
                    et[i]++;
                end
                mdc[i] = cyc; fpend[i] = 1; mwait[i] = 0;
            end
            if (new_senone) begin
                if (was_busy) merr[i] = 1;
                else begin
                    if (fn[i] < depth[i]) begin fbuf[i][fn[i]] = int'(current_score); fn[i]++; end
                    else merr[i] = 1;
                    if (last_senone) begin mbusy[i] = 1; mwait[i] = 1; end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic frame(input int best);
        foreach (fq[k]) begin
            new_senone = 1'b1; current_score = 16'(fq[k]); last_senone = (k == fq.size() - 1);
            tick();
        end
        new_senone = 1'b0; last_senone = 1'b0; current_score = '0;
        best_score = 16'(best); max_done = 1'b1;
        tick();
        max_done = 1'b0;
        fq.delete();
    endtask

    task automatic wait_idle(input int lim, input bit toggle);
        for (int k = 0; k < lim; k++) begin
            if (!bz[0] && !bz[1] && !v[0] && !v[1]) break;
            if (toggle) ready = (k % 3 == 0);
            tick();
        end
        ready = 1'b1;
        chk("idle_timeout", int'(bz[0] | bz[1] | v[0] | v[1]), 0);
        for (int i = 0; i < 2; i++) chk($sformatf("u%0d drained", i), et[i] - eh[i], 0);
    endtask

    task automatic expect_obs(input int i);
        chk($sformatf("u%0d beat_count", i), on[i], eq_s.size());
        for (int k = 0; k < on[i] && k < eq_s.size(); k++) begin
            chk($sformatf("u%0d lit_score%0d", i, k), obs_s[i][k], eq_s[k]);
            chk($sformatf("u%0d lit_last%0d", i, k), int'(obs_l[i][k]), int'(eq_l[k]));
        end
        eq_s.delete(); eq_l.delete();
    endtask

    task automatic lit(input int sc, input bit la);
        eq_s.push_back(sc); eq_l.push_back(la);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        on[0] = 0; on[1] = 0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_score", int'(s[0]), 0);
        chk("rst_last", int'(l[0]), 0);

        // Basic frame and first-beat latency
        on[0] = 0; on[1] = 0;
        fq.push_back(100); fq.push_back(-50); fq.push_back(300);
        frame(300);
        chk("lat_cycle1_valid", int'(v[0]), 0);
        tick();
        chk("lat_cycle2_valid", int'(v[0]), 1);
        wait_idle(40, 0);
        lit(-200, 0); lit(-350, 0); lit(0, 1); expect_obs(0);
        lit(-200, 0); lit(-350, 0); lit(0, 1); expect_obs(1);

        // Saturation in both directions
        on[0] = 0;
        fq.push_back(-32768); fq.push_back(32767);
        frame(32767);
        wait_idle(40, 0);
        lit(-32768, 0); lit(0, 1); expect_obs(0);
        on[0] = 0;
        fq.push_back(32767); fq.push_back(-32768);
        frame(-32768);
        wait_idle(40, 0);
        lit(32767, 0); lit(0, 1); expect_obs(0);

        // Backpressure, ready 1,0,0 repeating
        on[0] = 0; on[1] = 0;
        fq.push_back(5); fq.push_back(-3); fq.push_back(80); fq.push_back(0);
        fq.push_back(-100); fq.push_back(79); fq.push_back(1); fq.push_back(40);
        frame(80);
        wait_idle(100, 1);
        lit(-75, 0); lit(-83, 0); lit(0, 0); lit(-80, 0);
        lit(-180, 0); lit(-1, 0); lit(-79, 0); lit(-40, 1); expect_obs(0);
        lit(-75, 0); lit(-83, 0); lit(0, 0); lit(-80, 1); expect_obs(1);

        // Overflow on the 4-entry instance
        do_reset();
        for (int k = 1; k <= 6; k++) fq.push_back(k);
        frame(6);
        wait_idle(40, 0);
        lit(-5, 0); lit(-4, 0); lit(-3, 0); lit(-2, 1); expect_obs(1);
        chk("ovf_error_small", int'(er[1]), 1);
        chk("ovf_error_deep", int'(er[0]), 0);
        tick(); tick(); tick();
        chk("ovf_error_sticky", int'(er[1]), 1);

        // Strobes while busy, including on the final acceptance cycle
        do_reset();
        fq.push_back(10); fq.push_back(20); fq.push_back(30);
        frame(30);
        new_senone = 1'b1; last_senone = 1'b1; current_score = 16'sd999;
        tick();
        new_senone = 1'b0; last_senone = 1'b0;
        for (int k = 0; k < 20 && !(v[0] && l[0]); k++) tick();
        chk("busy_last_seen", int'(v[0] && l[0]), 1);
        new_senone = 1'b1; last_senone = 1'b1; current_score = 16'sd555;
        tick();
        new_senone = 1'b0; last_senone = 1'b0;
        wait_idle(40, 0);
        chk("busy_error0", int'(er[0]), 1);
        chk("busy_error1", int'(er[1]), 1);
        lit(-20, 0); lit(-10, 0); lit(0, 1); expect_obs(0);
        on[0] = 0;
        fq.push_back(-4); fq.push_back(6);
        frame(6);
        wait_idle(40, 0);
        lit(-10, 0); lit(0, 1); expect_obs(0);

        // Reset mid-drain after two beats
        do_reset();
        for (int k = 1; k <= 5; k++) fq.push_back(k);
        frame(5);
        for (int k = 0; k < 20 && on[0] < 2; k++) tick();
        chk("mid_beats_before", on[0], 2);
        reset = 1'b1;
        #1;
        chk("mid_valid0", int'(v[0]), 0);
        chk("mid_busy0", int'(bz[0]), 0);
        chk("mid_valid1", int'(v[1]), 0);
        chk("mid_busy1", int'(bz[1]), 0);
        tick();
        reset = 1'b0;
        tick();
        on[0] = 0; on[1] = 0;
        fq.push_back(-7);
        frame(-7);
        wait_idle(40, 0);
        lit(0, 1); expect_obs(0);
        lit(0, 1); expect_obs(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
